// File: rtl/apb3_completer_fifo.sv
// APB3 completer exposing a FIFO: DATA pushes/pops, STATUS reports level and
// sticky over/underflow flags, CTRL flushes and clears. Fixed wait-state count.
module apb3_completer_fifo #(
  parameter int unsigned AddressWidth = 20,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned Depth        = 8,
  parameter int unsigned WaitStates   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [AddressWidth-1:0] paddr,
  input  logic                    pwrite,
  input  logic                    psel,
  input  logic                    penable,
  input  logic [DataWidth-1:0]    pwdata,
  output logic [DataWidth-1:0]    prdata,
  output logic                    pready,
  output logic                    pslverr,
  output logic                    irq
);

  localparam int unsigned PtrW  = $clog2(Depth);
  localparam int unsigned CntW  = $clog2(Depth + 1);
  localparam int unsigned WaitW = 4;

  localparam logic [AddressWidth-1:0] AddrData   = AddressWidth'(0);
  localparam logic [AddressWidth-1:0] AddrStatus = AddressWidth'(4);
  localparam logic [AddressWidth-1:0] AddrCtrl   = AddressWidth'(8);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_e;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic               done_entry_c;
  logic               commit_c;

  logic [DataWidth-1:0] mem [Depth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;
  logic                 full_c, empty_c;
  logic [DataWidth-1:0] status_c;

  logic                 dec_push, dec_pop, dec_flush, dec_clr;
  logic                 dec_ovf, dec_udf, dec_err;
  logic [DataWidth-1:0] dec_rdata;

  logic                 op_push_q, op_pop_q, op_flush_q, op_clr_q;
  logic                 op_ovf_q, op_udf_q;
  logic [DataWidth-1:0] wdata_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Transfer sequencing: setup -> optional wait cycles -> single DONE cycle
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      ST_IDLE: begin
        if (psel && !penable) begin
          if (WaitStates == 0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
            wait_d  = WaitW'(WaitStates);
          end
        end
      end
      ST_WAIT: begin
        if (!psel) begin
          state_d = ST_IDLE;
        end else if (wait_q == WaitW'(1)) begin
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q - WaitW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign done_entry_c = (state_d == ST_DONE);
  assign commit_c     = (state_q == ST_DONE) && psel && penable;

  assign full_c  = (count_q == CntW'(Depth));
  assign empty_c = (count_q == '0);

  always_comb begin
    status_c       = '0;
    status_c[7:0]  = 8'(count_q);
    status_c[8]    = empty_c;
    status_c[9]    = full_c;
    status_c[10]   = ovf_q;
    status_c[11]   = udf_q;
  end

  // Address decode; sampled into the op registers as DONE is entered
  always_comb begin
    dec_push  = 1'b0;
    dec_pop   = 1'b0;
    dec_flush = 1'b0;
    dec_clr   = 1'b0;
    dec_ovf   = 1'b0;
    dec_udf   = 1'b0;
    dec_err   = 1'b0;
    dec_rdata = '0;
    if (paddr == AddrData) begin
      if (pwrite) begin
        if (full_c) begin
          dec_err = 1'b1;
          dec_ovf = 1'b1;
        end else begin
          dec_push = 1'b1;
        end
      end else if (empty_c) begin
        dec_err = 1'b1;
        dec_udf = 1'b1;
      end else begin
        dec_pop   = 1'b1;
        dec_rdata = mem[rd_ptr_q];
      end
    end else if (paddr == AddrStatus) begin
      if (pwrite) dec_err = 1'b1;
      else        dec_rdata = status_c;
    end else if (paddr == AddrCtrl) begin
      if (pwrite) begin
        dec_flush = pwdata[0];
        dec_clr   = pwdata[1];
      end
    end else begin
      dec_err = 1'b1;
    end
  end

  // Side effects land on the edge closing DONE; flush is applied last so it wins
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (commit_c) begin
      if (op_push_q) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
        count_d  = count_q + CntW'(1);
      end
      if (op_pop_q) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
        count_d  = count_q - CntW'(1);
      end
      if (op_ovf_q) ovf_d = 1'b1;
      if (op_udf_q) udf_d = 1'b1;
      if (op_clr_q) begin
        ovf_d = 1'b0;
        udf_d = 1'b0;
      end
      if (op_flush_q) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wait_q     <= '0;
      pready     <= 1'b0;
      pslverr    <= 1'b0;
      prdata     <= '0;
      op_push_q  <= 1'b0;
      op_pop_q   <= 1'b0;
      op_flush_q <= 1'b0;
      op_clr_q   <= 1'b0;
      op_ovf_q   <= 1'b0;
      op_udf_q   <= 1'b0;
      wdata_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      irq        <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      pready     <= done_entry_c;
      pslverr    <= done_entry_c & dec_err;
      prdata     <= done_entry_c ? dec_rdata : '0;
      op_push_q  <= done_entry_c & dec_push;
      op_pop_q   <= done_entry_c & dec_pop;
      op_flush_q <= done_entry_c & dec_flush;
      op_clr_q   <= done_entry_c & dec_clr;
      op_ovf_q   <= done_entry_c & dec_ovf;
      op_udf_q   <= done_entry_c & dec_udf;
      if (done_entry_c) wdata_q <= pwdata;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      irq        <= ovf_d | udf_d;
    end
  end

  // Storage is intentionally left unreset
  always_ff @(posedge clk) begin
    if (rst_n && commit_c && op_push_q) mem[wr_ptr_q] <= wdata_q;
  end

endmodule

// File: tb/tb_apb3_completer_fifo.sv
// Scoreboard bench for apb3_completer_fifo: a queue-based FIFO model predicts
// each response; a monitor checks responses as pready pulses.
module tb_apb3_completer_fifo;

  localparam int unsigned AW    = 20;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          irq;
    int            id;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic          penable;
  logic [DW-1:0] pwdata;
  logic [2:0]    psel_v;
  logic [DW-1:0] prdata_v [3];
  logic [2:0]    pready_v, pslverr_v, irq_v;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   xid    = 0;
  bit   mon_en = 1'b0;
  exp_t sb_q[$];
  exp_t mon_e;

  logic [DW-1:0] mq[$];
  bit            m_ovf = 1'b0;
  bit            m_udf = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb3_completer_fifo #(.AddressWidth(AW), .DataWidth(DW), .Depth(DEPTH), .WaitStates(1)) u_ws1 (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .pwrite(pwrite), .psel(psel_v[0]),
    .penable(penable), .pwdata(pwdata), .prdata(prdata_v[0]), .pready(pready_v[0]),
    .pslverr(pslverr_v[0]), .irq(irq_v[0]));

  apb3_completer_fifo #(.AddressWidth(AW), .DataWidth(DW), .Depth(DEPTH), .WaitStates(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .pwrite(pwrite), .psel(psel_v[1]),
    .penable(penable), .pwdata(pwdata), .prdata(prdata_v[1]), .pready(pready_v[1]),
    .pslverr(pslverr_v[1]), .irq(irq_v[1]));

  apb3_completer_fifo #(.AddressWidth(AW), .DataWidth(DW), .Depth(DEPTH), .WaitStates(3)) u_ws3 (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .pwrite(pwrite), .psel(psel_v[2]),
    .penable(penable), .pwdata(pwdata), .prdata(prdata_v[2]), .pready(pready_v[2]),
    .pslverr(pslverr_v[2]), .irq(irq_v[2]));

  function automatic int ws(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Register-map reference: a word queue plus two sticky bits
  function automatic exp_t model(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t          e;
    logic [DW-1:0] st;
    e.rdata = '0;
    e.err   = 1'b0;
    e.irq   = m_ovf | m_udf;
    e.id    = 0;
    if (a == AW'(0)) begin
      if (wr) begin
        if (mq.size() == DEPTH) begin
          e.err = 1'b1;
          m_ovf = 1'b1;
        end else begin
          mq.push_back(d);
        end
      end else if (mq.size() == 0) begin
        e.err = 1'b1;
        m_udf = 1'b1;
      end else begin
        e.rdata = mq.pop_front();
      end
    end else if (a == AW'(4)) begin
      if (wr) begin
        e.err = 1'b1;
      end else begin
        st      = DW'(mq.size());
        st[8]   = (mq.size() == 0);
        st[9]   = (mq.size() == DEPTH);
        st[10]  = m_ovf;
        st[11]  = m_udf;
        e.rdata = st;
      end
    end else if (a == AW'(8)) begin
      if (wr) begin
        if (d[0]) mq.delete();
        if (d[1]) begin
          m_ovf = 1'b0;
          m_udf = 1'b0;
        end
      end
    end else begin
      e.err = 1'b1;
    end
    return e;
  endfunction

  // Monitor: every pready pulse on the main DUT retires one scoreboard entry
  always @(negedge clk) begin
    if (mon_en) begin
      if (pready_v[0] !== 1'b1) begin
        chk("idle_pslverr", DW'(pslverr_v[0]), '0);
      end else if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pready: got pready=1 with no transfer outstanding");
      end else begin
        mon_e = sb_q.pop_front();
        chk($sformatf("prdata#%0d", mon_e.id), prdata_v[0], mon_e.rdata);
        chk($sformatf("pslverr#%0d", mon_e.id), DW'(pslverr_v[0]), DW'(mon_e.err));
        chk($sformatf("irq#%0d", mon_e.id), DW'(irq_v[0]), DW'(mon_e.irq));
      end
    end
  end

  task automatic xfer(input int k, input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, output int t_done);
    int   n;
    exp_t e;
    @(negedge clk);
    if (k == 0) begin
      e    = model(wr, a, d);
      e.id = xid;
      sb_q.push_back(e);
    end
    xid++;
    psel_v    = 3'b000;
    psel_v[k] = 1'b1;
    penable   = 1'b0;
    pwrite    = wr;
    paddr     = a;
    pwdata    = d;
    @(negedge clk);
    penable = 1'b1;
    n = 1;
    while (pready_v[k] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (pready_v[k] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL pready_timeout dut%0d: got no pready in %0d access cycles, expected %0d", k, n, ws(k) + 1);
    end else begin
      chk($sformatf("access_cycles_dut%0d", k), DW'(n), DW'(ws(k) + 1));
    end
    t_done = cyc;
  endtask

  task automatic idle();
    @(negedge clk);
    psel_v  = 3'b000;
    penable = 1'b0;
  endtask

  task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int t;
    xfer(0, 1'b1, a, d, t);
  endtask

  task automatic rd0(input logic [AW-1:0] a);
    int t;
    xfer(0, 1'b0, a, '0, t);
  endtask

  // Setup then drop psel while the main DUT sits in its wait cycle
  task automatic xfer_abort(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    psel_v  = 3'b001;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = a;
    pwdata  = d;
    @(negedge clk);
    psel_v  = 3'b000;
    penable = 1'b0;
  endtask

  task automatic b2b(input int k, input logic [AW-1:0] a);
    int t0, t1;
    t0 = 0;
    for (int i = 0; i < 3; i++) begin
      xfer(k, 1'b1, a, $urandom, t1);
      if (i > 0) chk($sformatf("b2b_period_dut%0d", k), DW'(t1 - t0), DW'(2 + ws(k)));
      t0 = t1;
    end
    idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int            r;
    int            t;
    bit            wr;
    logic [AW-1:0] a;

    rst_n   = 1'b0;
    psel_v  = 3'b000;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    repeat (3) @(negedge clk);
    chk("reset_pready",  DW'(pready_v[0]),  '0);
    chk("reset_pslverr", DW'(pslverr_v[0]), '0);
    chk("reset_prdata",  prdata_v[0],       '0);
    chk("reset_irq",     DW'(irq_v[0]),     '0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // FIFO ordering and empty status
    rd0(AW'(4));
    wr0(AW'(0), 32'hA1);
    wr0(AW'(0), 32'hA2);
    rd0(AW'(0));
    rd0(AW'(0));
    rd0(AW'(4));

    // Overflow, then sticky clear
    for (int i = 0; i < 5; i++) wr0(AW'(0), $urandom);
    rd0(AW'(4));
    idle();
    chk("irq_after_overflow", DW'(irq_v[0]), DW'(1));
    wr0(AW'(8), 32'h2);
    idle();
    chk("irq_after_clear", DW'(irq_v[0]), '0);
    rd0(AW'(4));

    // Flush, underflow, combined flush+clear
    wr0(AW'(8), 32'h1);
    rd0(AW'(0));
    rd0(AW'(4));
    for (int i = 0; i < 3; i++) wr0(AW'(0), $urandom);
    wr0(AW'(8), 32'h1);
    rd0(AW'(4));
    wr0(AW'(8), 32'h3);
    rd0(AW'(4));

    // Error decodes and CTRL readback
    wr0(AW'(0), 32'h55);
    rd0(AW'(32'h10));
    rd0(AW'(6));
    wr0(AW'(4), 32'hFFFF);
    rd0(AW'(8));
    rd0(AW'(4));

    // Aborted push leaves the count alone
    xfer_abort(AW'(0), 32'hDEAD);
    idle();
    rd0(AW'(4));
    rd0(AW'(0));

    // Reset in the middle of a push with two entries queued and irq raised
    rd0(AW'(0));
    wr0(AW'(0), 32'h11);
    wr0(AW'(0), 32'h22);
    @(negedge clk);
    psel_v  = 3'b001;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = AW'(0);
    pwdata  = 32'h33;
    @(negedge clk);
    penable = 1'b1;
    rst_n   = 1'b0;
    @(negedge clk);
    psel_v  = 3'b000;
    penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    @(negedge clk);
    chk("irq_after_reset", DW'(irq_v[0]), '0);
    rd0(AW'(4));
    wr0(AW'(0), 32'hC0FFEE);
    rd0(AW'(0));
    idle();

    // Wait-state latency and back-to-back throughput on all three variants
    b2b(1, AW'(0));
    b2b(2, AW'(0));
    wr0(AW'(8), 32'h1);
    b2b(0, AW'(0));

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        xfer_abort(AW'(0), $urandom);
      end else begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: a = AW'(0);
          5, 6:          a = AW'(4);
          7:             a = AW'(8);
          8:             a = AW'(32'h10);
          default:       a = AW'($urandom);
        endcase
        wr = 1'($urandom_range(0, 1));
        xfer(0, wr, a, $urandom, t);
        if (r < 4) idle();
      end
    end

    repeat (3) idle();
    chk("scoreboard_drained", DW'(sb_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb3_completer_fifo.md
APB3_COMPLETER_FIFO -- requirements
Module: apb3_completer_fifo

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low. Ports are named clk and rst_n.
REQ-002 Parameter AddressWidth, default 20: APB3 address width in bits.
REQ-003 Parameter DataWidth, default 32: APB3 data width in bits; legal range 16-32.
REQ-004 Parameter Depth, default 8: FIFO entries; legal range 2-255.
REQ-005 Parameter WaitStates, default 1: access-phase cycles with pready=0 before completion; legal range 0-15.
REQ-006 Port clk, input, 1: rising-edge clock.
REQ-007 Port rst_n, input, 1: synchronous active-low reset.
REQ-008 Port paddr, input, AddressWidth: byte address.
REQ-009 Port pwrite, input, 1: 1=write, 0=read.
REQ-010 Port psel, input, 1: completer select.
REQ-011 Port penable, input, 1: access phase.
REQ-012 Port pwdata, input, DataWidth: write data.
REQ-013 Port prdata, output, DataWidth: read data; valid only while pready=1.
REQ-014 Port pready, output, 1: transfer completion.
REQ-015 Port pslverr, output, 1: transfer error; valid only while pready=1, otherwise 0.
REQ-016 Port irq, output, 1: level interrupt, equal to overflow OR underflow sticky flag.

Function
REQ-017 Register map, full-width address compare: 0x0 DATA (write pushes, read pops); 0x4 STATUS (read-only); 0x8 CTRL (write-only, reads return 0 with no error).
REQ-018 STATUS layout SHALL be: [7:0] count, [8] empty, [9] full, [10] overflow sticky, [11] underflow sticky, all other bits 0.
REQ-019 CTRL write SHALL act as follows: bit0=1 flushes the FIFO (count=0); bit1=1 clears both sticky flags. Both bits set in one write perform both actions.
REQ-020 The transfer FSM SHALL have states IDLE, WAIT and DONE. pready=1 only in DONE.
REQ-021 IDLE -> DONE when psel=1 and penable=0 at a clock edge and WaitStates=0. IDLE -> WAIT under the same condition when WaitStates>0, with the wait counter loaded to WaitStates.
REQ-022 WAIT: the counter decrements each cycle; when it reaches 1, the next state is DONE. With WaitStates=N, pready rises in access cycle N+1.
REQ-023 DONE -> IDLE unconditionally after one cycle, so pready is a single-cycle pulse.
REQ-024 If psel=0 in WAIT or DONE, the FSM SHALL return to IDLE (aborted transfer) with no side effects and no sticky update.
REQ-025 prdata, pslverr and the decoded operation SHALL be registered on entry to DONE. prdata is 0 for writes, errors and non-readable addresses.
REQ-026 Side effects (push, pop, flush, sticky set/clear) SHALL commit at the clock edge ending the DONE cycle, only if psel=1 and penable=1 at that edge.
REQ-027 A DATA read SHALL return the head entry zero-extended. A DATA write SHALL push pwdata captured at DONE entry.
REQ-028 A DATA write when full SHALL give pslverr=1 and set overflow; no push occurs and the contents are unchanged.
REQ-029 A DATA read when empty SHALL give pslverr=1, prdata=0 and set underflow; no pop occurs.
REQ-030 The following SHALL give pslverr=1 with no side effects: a write to STATUS, paddr[1:0]!=0, or any unmapped address.
REQ-031 Read and write pointers SHALL wrap modulo Depth; count SHALL range 0..Depth with no wrap.
REQ-032 A new setup phase SHALL be accepted in IDLE on the cycle immediately after DONE, so back-to-back transfers take 2+WaitStates cycles each.
REQ-033 A sticky set and a CTRL clear never coincide (one transfer at a time). If a flush and an overflow were evaluated together, the flush SHALL win.

Reset
REQ-034 On rst_n=0 at a clock edge the block SHALL enter: FSM IDLE, pready=0, pslverr=0, prdata=0, irq=0, count=0, pointers=0, sticky flags=0. FIFO storage is not reset.
REQ-035 A reset asserted mid-transfer SHALL abort it with no side effects. The first transfer after rst_n=1 SHALL be handled normally.

Verification (Depth=4, WaitStates=1 unless noted)
REQ-036 Write 0xA1,0xA2 to 0x0, then read 0x0 twice -> prdata 0xA1 then 0xA2; pslverr=0; STATUS read = 0x100.
REQ-037 Push 5 words -> 5th transfer gives pslverr=1; STATUS=0x604; irq=1. Write 0x2 to 0x8 -> STATUS=0x204, irq=0.
REQ-038 Read 0x0 when empty -> pslverr=1, prdata=0, STATUS bit11=1. Write 0x1 to 0x8 after 3 pushes -> STATUS bit8=1, count=0.
REQ-039 Timing: WaitStates=0 -> pready in first access cycle. WaitStates=3 -> pready in 4th access cycle. Back-to-back writes -> one transfer every 2+WaitStates cycles.
REQ-040 Read 0x10, read 0x6, write 0x4 -> each gives pslverr=1 with no state change. Drop psel during WAIT on a push -> count unchanged.
REQ-041 Assert rst_n=0 during the WAIT of a push with count=2 -> after reset, count=0, irq=0. The next write/read pair round-trips data correctly.
